bitonic_sort_iter: RTL

BITONIC_SORT_ITER -- requirements
Module: bitonic_sort_iter

---
 rtl/bitonic_sort_iter_if.sv | 27 ++
 rtl/bitonic_sort_iter.sv | 107 ++++++++++
 2 files changed

// File: rtl/bitonic_sort_iter_if.sv
// bitonic_sort_iter_if: key-vector handshake bundle.
// master drives vectors in and results out; slave is the sorter.
interface bitonic_sort_iter_if #(
  parameter int N      = 8,
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(N)
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N-1:0][DATA_W-1:0]   in_data;
  logic                       descending;
  logic                       out_valid;
  logic                       out_ready;
  logic [N-1:0][DATA_W-1:0]   out_data;
  logic [N-1:0][IDX_W-1:0]    out_index;
  logic                       busy;

  modport master (
    output in_valid, in_data, descending, out_ready,
    input  in_ready, out_valid, out_data, out_index, busy
  );

  modport slave (
    input  in_valid, in_data, descending, out_ready,
    output in_ready, out_valid, out_data, out_index, busy
  );
endinterface

// File: rtl/bitonic_sort_iter.sv
// bitonic_sort_iter: iterative bitonic sorter, one compare-exchange
// layer per cycle, with original-position tags carried alongside keys.
module bitonic_sort_iter #(
  parameter int N      = 8,
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  bitonic_sort_iter_if.slave bus
);
  localparam int LW = $clog2(N);
  // k climbs to 2N after the final layer, so it needs two spare bits.
  localparam int KW = LW + 2;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                   state;
  logic [N-1:0][DATA_W-1:0] key, key_nx, out_data_q;
  logic [N-1:0][IDX_W-1:0]  idx, idx_nx, out_index_q;
  logic [KW-1:0]            k, j;
  logic                     dir;
  logic                     fin;

  // One compare-exchange layer over every (i, i^j) pair with l > i.
  always_comb begin
    key_nx = key;
    idx_nx = idx;
    for (int i = 0; i < N; i++) begin
      logic [LW-1:0] l;
      logic up, gt, lt;
      l  = LW'(i) ^ j[LW-1:0];
      up = ((i & int'(k)) == 0) ^ dir;
      if (SIGNED != 0) begin
        gt = $signed(key[i]) > $signed(key[l]);
        lt = $signed(key[i]) < $signed(key[l]);
      end else begin
        gt = key[i] > key[l];
        lt = key[i] < key[l];
      end
      if ((l > LW'(i)) && (up ? gt : lt)) begin
        key_nx[i] = key[l];
        key_nx[l] = key[i];
        idx_nx[i] = idx[l];
        idx_nx[l] = idx[i];
      end
    end
  end

  // Sequencer: accept, walk the (k,j) layers, publish, wait for handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key         <= '0;
      idx         <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      k           <= '0;
      j           <= '0;
      dir         <= 1'b0;
      fin         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            key <= bus.in_data;
            for (int i = 0; i < N; i++) idx[i] <= IDX_W'(i);
            dir   <= bus.descending;
            k     <= KW'(2);
            j     <= KW'(1);
            fin   <= 1'b0;
            state <= SORT;
          end
        end
        SORT: begin
          if (fin) begin
            out_data_q  <= key;
            out_index_q <= idx;
            fin         <= 1'b0;
            state       <= DONE;
          end else begin
            key <= key_nx;
            idx <= idx_nx;
            if (j == KW'(1)) begin
              if (k == KW'(N)) fin <= 1'b1;
              k <= k << 1;
              j <= k;
            end else begin
              j <= j >> 1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
endmodule
